period_meas_ctrl: RTL

Measurement controller that sequences period capture on a single-bit monitored signal, counting `clk` cycles between consecutive rising edges. It runs a start/done measurement window over 2**N_LOG2 periods and reports average, minimum and maximum period plus a timeout flag. It sits beside the clock/period checking benches as the synthesizable counterpart to their assertion-based period measurement, and is driven by a test sequencer or CSR block.

---
 rtl/period_meas_pkg.sv | 47 ++++
 rtl/period_meas_ctrl_rise_detect.sv | 21 ++
 rtl/period_meas_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/period_meas_pkg.sv
// Shared types for the period measurement controller: FSM states, the
// priority-ordered window events and the result record.
package period_meas_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Events seen by an active window; a lower encoding wins when several
  // conditions are present in the same cycle.
  typedef enum logic [1:0] {
    EV_ABORT   = 2'd0,
    EV_TIMEOUT = 2'd1,
    EV_RISE    = 2'd2,
    EV_NONE    = 2'd3
  } event_t;

  localparam int PM_CNT_W = 16;

  typedef struct packed {
    logic [PM_CNT_W-1:0] period;
    logic [PM_CNT_W-1:0] min_p;
    logic [PM_CNT_W-1:0] max_p;
    logic                timeout;
  } period_result_t;

  // Resolve the window event. An edge arriving on the very cycle the counter
  // hits its limit is still a valid sample, so timeout needs "no rise".
  function automatic event_t pick_event(input logic abort_req,
                                        input logic at_limit,
                                        input logic rise);
    event_t ev;
    if (abort_req)
      ev = EV_ABORT;
    else if (at_limit && !rise)
      ev = EV_TIMEOUT;
    else if (rise)
      ev = EV_RISE;
    else
      ev = EV_NONE;
    return ev;
  endfunction

endpackage

// File: rtl/period_meas_ctrl_rise_detect.sv
// Registered rising-edge detector for a signal already synchronous to clk.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  // Remember last cycle's level so a 0->1 step can be seen.
  always_ff @(posedge clk) begin
    if (rst)
      sig_q <= 1'b0;
    else
      sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/period_meas_ctrl.sv
// Period measurement controller: counts clk cycles between rising edges of
// sig_in over a window of 2**N_LOG2 periods and reports avg/min/max.
module period_meas_ctrl
  import period_meas_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int N_LOG2  = 2,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] min_period,
  output logic [CNT_W-1:0] max_period,
  output logic             timeout_err
);

  localparam int               ACC_W      = CNT_W + N_LOG2;
  localparam int               NS_W       = N_LOG2 + 1;
  localparam logic [NS_W-1:0]  NSAMP_FULL = NS_W'(1 << N_LOG2);
  localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [NS_W-1:0]    nsamp_q, nsamp_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   min_q, min_d;
  logic [CNT_W-1:0]   max_q, max_d;
  logic               tout_q, tout_d;

  logic               rise;
  event_t             ev;
  logic [ACC_W-1:0]   acc_next;
  logic [NS_W-1:0]    nsamp_next;
  logic [CNT_W-1:0]   avg_partial;
  logic [CNT_W-1:0]   avg_final;

  rise_detect u_rise (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (sig_in),
    .rise_o (rise)
  );

  // cnt_q holds the current sample value on the cycle its closing edge arrives.
  assign acc_next    = acc_q + ACC_W'(cnt_q);
  assign nsamp_next  = nsamp_q + NS_W'(1);
  assign avg_partial = CNT_W'(acc_q >> N_LOG2);
  assign avg_final   = CNT_W'(acc_next >> N_LOG2);
  assign ev          = pick_event(abort, cnt_q == CNT_LIMIT, rise);

  // Next-state and datapath updates for the measurement window.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    nsamp_d  = nsamp_q;
    period_d = period_q;
    min_d    = min_q;
    max_d    = max_q;
    tout_d   = tout_q;
    case (state_q)
      IDLE: begin
        // An edge coincident with start is dropped: rise is not looked at here.
        if (start) begin
          state_d = ARM;
          cnt_d   = '0;
          acc_d   = '0;
          nsamp_d = '0;
          tout_d  = 1'b0;
          min_d   = '1;
          max_d   = '0;
        end
      end
      ARM: begin
        case (ev)
          EV_ABORT:   state_d = IDLE;
          EV_TIMEOUT: begin
            tout_d   = 1'b1;
            period_d = avg_partial;
            state_d  = DONE;
          end
          EV_RISE: begin
            cnt_d   = CNT_W'(1);
            state_d = MEASURE;
          end
          default:    cnt_d = cnt_q + CNT_W'(1);
        endcase
      end
      MEASURE: begin
        case (ev)
          EV_ABORT:   state_d = IDLE;
          EV_TIMEOUT: begin
            tout_d   = 1'b1;
            period_d = avg_partial;
            state_d  = DONE;
          end
          EV_RISE: begin
            acc_d   = acc_next;
            nsamp_d = nsamp_next;
            cnt_d   = CNT_W'(1);
            if (cnt_q < min_q) min_d = cnt_q;
            if (cnt_q > max_q) max_d = cnt_q;
            if (nsamp_next == NSAMP_FULL) begin
              period_d = avg_final;
              state_d  = DONE;
            end
          end
          default:    cnt_d = cnt_q + CNT_W'(1);
        endcase
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      nsamp_q  <= '0;
      period_q <= '0;
      min_q    <= '0;
      max_q    <= '0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      nsamp_q  <= nsamp_d;
      period_q <= period_d;
      min_q    <= min_d;
      max_q    <= max_d;
      tout_q   <= tout_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign period      = period_q;
  assign min_period  = min_q;
  assign max_period  = max_q;
  assign timeout_err = tout_q;

endmodule
